// File: rtl/bist_pkg.sv
// Shared definitions for the BIST run sequencer: FSM state encoding and
// BIST_STATUS nibble codes reported by the engine.
package bist_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [3:0] STATUS_OK   = 4'hF;
  localparam logic [3:0] STATUS_FAIL = 4'h5;

endpackage

// File: rtl/bist_run_sequencer_if.sv
// Connection between the run sequencer (master) and the TAP BIST engine (slave).
interface bist_run_sequencer_if;

  logic        bist_tlr;
  logic        bist_runbist_select;
  logic        bist_reset_sm;
  logic        bist_error;
  logic [15:0] bist_status;

  modport master (
    output bist_tlr,
    output bist_runbist_select,
    input  bist_reset_sm,
    input  bist_error,
    input  bist_status
  );

  modport slave (
    input  bist_tlr,
    input  bist_runbist_select,
    output bist_reset_sm,
    output bist_error,
    output bist_status
  );

endinterface

// File: rtl/bist_watchdog.sv
// Per-iteration watchdog: counts enabled cycles and flags the cycle in which
// the count reaches TIMEOUT-1.
module bist_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  // Cycle counter, restarted at the beginning of every iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  assign expire = enable && (count == LAST);

endmodule

// File: rtl/bist_run_sequencer.sv
// Repeats the TAP BIST engine run loop_count times, tallying failing iterations
// and capturing the status of the first failure.
module bist_run_sequencer
  import bist_pkg::*;
#(
  parameter int LOOP_W       = 8,
  parameter int TIMEOUT      = 1024,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LOOP_W-1:0]    loop_count,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic                 aborted,
  output logic [LOOP_W-1:0]    fail_count,
  output logic [LOOP_W-1:0]    first_fail_iter,
  output logic [15:0]          first_fail_status,
  bist_run_sequencer_if.master bist
);

  logic [2:0]        state, state_next;
  logic [LOOP_W-1:0] loop_q, loop_next;
  logic [LOOP_W-1:0] iter, iter_next;
  logic [LOOP_W-1:0] fc_next, ffi_next;
  logic [15:0]       ffs_next;
  logic [15:0]       stat_q, stat_next;
  logic              to_next, ab_next, pass_next;
  logic              wd_expire;
  logic              last_iter;

  bist_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == S_CLEAR),
    .enable (state == S_RUN),
    .expire (wd_expire)
  );

  assign last_iter = (iter + LOOP_W'(1)) == loop_q;

  // Next state and next result values; pass is settled on entry to FINISH so
  // it is already valid while done is high
  always_comb begin
    state_next = state;
    loop_next  = loop_q;
    iter_next  = iter;
    fc_next    = fail_count;
    ffi_next   = first_fail_iter;
    ffs_next   = first_fail_status;
    stat_next  = stat_q;
    to_next    = timeout;
    ab_next    = aborted;
    pass_next  = pass;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_next = S_CLEAR;
          loop_next  = (loop_count == '0) ? LOOP_W'(1) : loop_count;
          iter_next  = '0;
          fc_next    = '0;
          ffi_next   = '0;
          ffs_next   = '0;
          to_next    = 1'b0;
          ab_next    = 1'b0;
          pass_next  = 1'b0;
        end
      end
      S_CLEAR: begin
        if (abort) begin
          state_next = S_FINISH;
          ab_next    = 1'b1;
        end else begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_next = S_FINISH;
          ab_next    = 1'b1;
        end else if (bist.bist_reset_sm) begin
          state_next = S_CHECK;
          stat_next  = bist.bist_status;
        end else if (wd_expire) begin
          state_next = S_FINISH;
          to_next    = 1'b1;
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_next = S_FINISH;
          ab_next    = 1'b1;
        end else begin
          if (bist.bist_error) begin
            if (fail_count != '1) fc_next = fail_count + LOOP_W'(1);
            if (fail_count == '0) begin
              ffi_next = iter;
              ffs_next = stat_q;
            end
          end
          iter_next = iter + LOOP_W'(1);
          if (last_iter || (STOP_ON_FAIL && bist.bist_error)) state_next = S_FINISH;
          else state_next = S_CLEAR;
        end
      end
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    if ((state != S_FINISH) && (state_next == S_FINISH)) begin
      pass_next = (fc_next == '0) && !to_next && !ab_next;
    end
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      loop_q            <= '0;
      iter              <= '0;
      fail_count        <= '0;
      first_fail_iter   <= '0;
      first_fail_status <= '0;
      stat_q            <= '0;
      timeout           <= 1'b0;
      aborted           <= 1'b0;
      pass              <= 1'b0;
    end else begin
      state             <= state_next;
      loop_q            <= loop_next;
      iter              <= iter_next;
      fail_count        <= fc_next;
      first_fail_iter   <= ffi_next;
      first_fail_status <= ffs_next;
      stat_q            <= stat_next;
      timeout           <= to_next;
      aborted           <= ab_next;
      pass              <= pass_next;
    end
  end

  assign busy                     = (state != S_IDLE);
  assign done                     = (state == S_FINISH);
  assign bist.bist_tlr            = (state == S_CLEAR) || (state == S_FINISH);
  assign bist.bist_runbist_select = (state == S_RUN);

endmodule

// File: tb/tb_bist_run_sequencer.sv
// Bench for bist_run_sequencer: two instances (STOP_ON_FAIL 0 and 1, TIMEOUT 64)
// each paired with a simple BIST engine model, driven by a vector table plus
// hand-written abort and reset sequences.
module tb_bist_run_sequencer;
  import bist_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [7:0] loop_count = 8'd0;

  logic [7:0]  eng_k = 8'd10;
  logic [7:0]  eng_mask = 8'd0;
  logic [15:0] eng_fs = 16'd0;
  logic        eng_hang = 1'b0;
  logic        eng_clr = 1'b0;

  logic        busy_v [2];
  logic        done_v [2];
  logic        pass_v [2];
  logic        to_v   [2];
  logic        ab_v   [2];
  logic        tlr_v  [2];
  logic        rs_v   [2];
  logic [7:0]  fc_v   [2];
  logic [7:0]  ffi_v  [2];
  logic [15:0] ffs_v  [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen_u
    bist_run_sequencer_if bus ();

    bist_run_sequencer #(
      .LOOP_W       (8),
      .TIMEOUT      (64),
      .STOP_ON_FAIL (g == 1)
    ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start             (start),
      .abort             (abort),
      .loop_count        (loop_count),
      .busy              (busy_v[g]),
      .done              (done_v[g]),
      .pass              (pass_v[g]),
      .timeout           (to_v[g]),
      .aborted           (ab_v[g]),
      .fail_count        (fc_v[g]),
      .first_fail_iter   (ffi_v[g]),
      .first_fail_status (ffs_v[g]),
      .bist              (bus)
    );

    logic [7:0] cnt;
    logic [7:0] run_idx;
    logic       err;

    assign bus.bist_reset_sm = bus.bist_runbist_select && !eng_hang && (cnt == eng_k - 8'd1);
    assign bus.bist_error    = err;
    assign bus.bist_status   = eng_mask[run_idx[2:0]] ? (eng_fs ^ {run_idx[3:0], 12'h000})
                                                      : {12'h000, STATUS_OK};
    assign tlr_v[g] = bus.bist_tlr;
    assign rs_v[g]  = bus.bist_runbist_select;

    // Engine model: run lasts eng_k RUN cycles, error flagged per iteration from eng_mask
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= 8'd0; run_idx <= 8'd0; err <= 1'b0;
      end else begin
        if (eng_clr) run_idx <= 8'd0;
        if (bus.bist_tlr) begin
          cnt <= 8'd0;
          err <= 1'b0;
        end else if (bus.bist_runbist_select) begin
          if (bus.bist_reset_sm) begin
            err <= eng_mask[run_idx[2:0]];
            if (!eng_clr) run_idx <= run_idx + 8'd1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
      end
    end
  end

  typedef struct {
    logic [7:0]  loop_count;
    logic [7:0]  k;
    logic [7:0]  mask;
    logic [15:0] fs;
    bit          hang;
    int          sel;
    int          exp_cycles;
    int          exp_tlr;
    logic [7:0]  exp_fc;
    logic [7:0]  exp_ffi;
    logic [15:0] exp_ffs;
    bit          exp_pass;
    bit          exp_to;
  } vec_t;

  vec_t vecs [6];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait (bounded) until both instances are back in IDLE
  task automatic wait_idle();
    int n = 0;
    while ((busy_v[0] || busy_v[1]) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check_output("idle_wait", {31'd0, busy_v[0] | busy_v[1]}, 32'd0);
  endtask

  task automatic apply_stimulus(input int i);
    vec_t v = vecs[i];
    int   cyc = 0;
    int   tlrs = 0;
    bit   seen = 0;
    @(negedge clk);
    eng_k = v.k; eng_mask = v.mask; eng_fs = v.fs; eng_hang = v.hang;
    eng_clr = 1'b1; loop_count = v.loop_count; start = 1'b1;
    while (!seen && cyc < 2000) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 1) begin start = 1'b0; eng_clr = 1'b0; end
      if (tlr_v[v.sel]) tlrs++;
      if (done_v[v.sel]) seen = 1;
    end
    check_output($sformatf("v%0d done_seen", i), {31'd0, seen}, 32'd1);
    check_output($sformatf("v%0d cycles", i), cyc, v.exp_cycles);
    check_output($sformatf("v%0d tlr_pulses", i), tlrs, v.exp_tlr);
    check_output($sformatf("v%0d runbist_sel", i), {31'd0, rs_v[v.sel]}, 32'd0);
    check_output($sformatf("v%0d pass", i), {31'd0, pass_v[v.sel]}, {31'd0, v.exp_pass});
    check_output($sformatf("v%0d timeout", i), {31'd0, to_v[v.sel]}, {31'd0, v.exp_to});
    check_output($sformatf("v%0d aborted", i), {31'd0, ab_v[v.sel]}, 32'd0);
    check_output($sformatf("v%0d fail_count", i), {24'd0, fc_v[v.sel]}, {24'd0, v.exp_fc});
    check_output($sformatf("v%0d first_iter", i), {24'd0, ffi_v[v.sel]}, {24'd0, v.exp_ffi});
    check_output($sformatf("v%0d first_status", i), {16'd0, ffs_v[v.sel]}, {16'd0, v.exp_ffs});
    @(posedge clk); #1;
    check_output($sformatf("v%0d done_pulse", i), {31'd0, done_v[v.sel]}, 32'd0);
    check_output($sformatf("v%0d pass_hold", i), {31'd0, pass_v[v.sel]}, {31'd0, v.exp_pass});
    wait_idle();
  endtask

  initial begin
    //        lc     k      mask    fs        hang sel cyc tlr fc    ffi   ffs        pass to
    vecs[0] = '{8'd3, 8'd10, 8'h00, 16'h0000, 0,   0,  37, 4,  8'd0, 8'd0, 16'h0000, 1,   0};
    vecs[1] = '{8'd4, 8'd10, 8'h04, 16'h83C5, 0,   0,  49, 5,  8'd1, 8'd2, 16'hA3C5, 0,   0};
    vecs[2] = '{8'd5, 8'd10, 8'h02, 16'h4B75, 0,   1,  25, 3,  8'd1, 8'd1, 16'h5B75, 0,   0};
    vecs[3] = '{8'd1, 8'd10, 8'h00, 16'h0000, 1,   0,  66, 2,  8'd0, 8'd0, 16'h0000, 0,   1};
    vecs[4] = '{8'd0, 8'd3,  8'h00, 16'h0000, 0,   0,  6,  2,  8'd0, 8'd0, 16'h0000, 1,   0};
    vecs[5] = '{8'd3, 8'd2,  8'h07, 16'h1235, 0,   0,  13, 4,  8'd3, 8'd0, 16'h1235, 0,   0};

    repeat (3) @(posedge clk);
    #1;
    check_output("rst busy", {31'd0, busy_v[0]}, 32'd0);
    check_output("rst tlr", {31'd0, tlr_v[0]}, 32'd0);
    check_output("rst runbist_sel", {31'd0, rs_v[0]}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check_output("post-rst done", {31'd0, done_v[0]}, 32'd0);
    check_output("post-rst pass", {31'd0, pass_v[0]}, 32'd0);
    check_output("post-rst fail_count", {24'd0, fc_v[0]}, 32'd0);
    check_output("post-rst timeout", {31'd0, to_v[0]}, 32'd0);

    for (int i = 0; i < 6; i++) apply_stimulus(i);

    // Abort during the second iteration's RUN, with an ignored start while busy
    begin
      int cyc = 0;
      @(negedge clk);
      eng_k = 8'd10; eng_mask = 8'h00; eng_hang = 1'b0; eng_clr = 1'b1;
      loop_count = 8'd3; start = 1'b1;
      while (cyc < 17) begin
        @(posedge clk); #1; cyc++;
        if (cyc == 1) begin start = 1'b0; eng_clr = 1'b0; end
        if (cyc == 15) start = 1'b1;
        if (cyc == 16) begin
          check_output("abort pre runbist_sel", {31'd0, rs_v[0]}, 32'd1);
          check_output("abort pre done", {31'd0, done_v[0]}, 32'd0);
          start = 1'b0; abort = 1'b1;
        end
      end
      check_output("abort done", {31'd0, done_v[0]}, 32'd1);
      check_output("abort aborted", {31'd0, ab_v[0]}, 32'd1);
      check_output("abort pass", {31'd0, pass_v[0]}, 32'd0);
      check_output("abort runbist_sel", {31'd0, rs_v[0]}, 32'd0);
      abort = 1'b0;
      @(posedge clk); #1;
      check_output("abort busy after", {31'd0, busy_v[0]}, 32'd0);
      check_output("abort aborted hold", {31'd0, ab_v[0]}, 32'd1);
      check_output("abort fail_count", {24'd0, fc_v[0]}, 32'd0);
      wait_idle();
    end

    // start and abort together in IDLE: abort wins
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    check_output("start+abort busy", {31'd0, busy_v[0]}, 32'd0);
    start = 1'b0; abort = 1'b0;

    // Reset mid-RUN returns to IDLE immediately
    begin
      int cyc = 0;
      @(negedge clk);
      eng_k = 8'd10; eng_mask = 8'h00; eng_clr = 1'b1; loop_count = 8'd2; start = 1'b1;
      while (cyc < 5) begin
        @(posedge clk); #1; cyc++;
        if (cyc == 1) begin start = 1'b0; eng_clr = 1'b0; end
      end
      check_output("mid-run runbist_sel", {31'd0, rs_v[0]}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_output("rst busy now", {31'd0, busy_v[0]}, 32'd0);
      check_output("rst runbist_sel now", {31'd0, rs_v[0]}, 32'd0);
      check_output("rst tlr now", {31'd0, tlr_v[0]}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
    end

    apply_stimulus(4);
    apply_stimulus(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] global timeout");
  end

endmodule
